// File: rtl/transposed_buffer_reader_pkg.sv
// Shared constants and drain-FSM encoding for the transposed buffer
// reader of the interpolation datapath.
package transposed_buffer_reader_pkg;

  localparam int SAMPLE_W = 11;
  localparam int ROWS     = 9;
  localparam int COLS     = 4;
  localparam int COL_W    = ROWS * SAMPLE_W;
  localparam int FILL_W   = 4;
  localparam int IDX_W    = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_e;

endpackage

// File: rtl/transposed_buffer_reader.sv
// Write-side row counter and read-side column streamer for the 4x9
// transposed buffer; a holding register decouples filling from draining.
module transposed_buffer_reader
  import transposed_buffer_reader_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RST_ASYNC_N,
  input  logic                    ROW_VALID,
  output logic                    ROW_READY,
  output logic                    WRITE_EN,
  input  logic signed [COL_W-1:0] COL_IN_0,
  input  logic signed [COL_W-1:0] COL_IN_1,
  input  logic signed [COL_W-1:0] COL_IN_2,
  input  logic signed [COL_W-1:0] COL_IN_3,
  output logic signed [COL_W-1:0] COL_OUT,
  output logic [IDX_W-1:0]        COL_IDX,
  output logic                    COL_VALID,
  input  logic                    COL_READY,
  output logic                    COL_LAST,
  output logic [FILL_W-1:0]       FILL_CNT,
  output drain_state_e            DRAIN_STATE
);

  // Handshakes: a transfer happens on a rising CLK edge where valid and
  // ready are both high; valid and its payload stay stable until then.

  logic [FILL_W-1:0]       fill_cnt_q, fill_cnt_d;
  drain_state_e            state_q, state_d;
  logic [IDX_W-1:0]        col_idx_q, col_idx_d;
  logic signed [COL_W-1:0] hold_q [COLS];
  logic signed [COL_W-1:0] hold_d [COLS];
  logic signed [COL_W-1:0] col_in [COLS];

  logic full;
  logic accept;
  logic col_fire;
  logic drain_end;
  logic capture;

  always_comb begin
    col_in[0] = COL_IN_0;
    col_in[1] = COL_IN_1;
    col_in[2] = COL_IN_2;
    col_in[3] = COL_IN_3;

    full      = (fill_cnt_q == FILL_W'(ROWS));
    accept    = ROW_VALID && !full;
    col_fire  = (state_q == ST_DRAIN) && COL_READY;
    drain_end = col_fire && (col_idx_q == IDX_W'(COLS - 1));
    // A full block is taken either into an empty holder or in the very
    // cycle the last column leaves, so consecutive blocks have no bubble.
    capture   = full && ((state_q == ST_IDLE) || drain_end);

    fill_cnt_d = fill_cnt_q;
    state_d    = state_q;
    col_idx_d  = col_idx_q;
    for (int c = 0; c < COLS; c++) hold_d[c] = hold_q[c];

    if (capture) begin
      for (int c = 0; c < COLS; c++) hold_d[c] = col_in[c];
      fill_cnt_d = '0;
      state_d    = ST_DRAIN;
      col_idx_d  = '0;
    end else begin
      if (accept) fill_cnt_d = fill_cnt_q + 1'b1;
      if (drain_end) begin
        state_d   = ST_IDLE;
        col_idx_d = '0;
      end else if (col_fire) begin
        col_idx_d = col_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      fill_cnt_q <= '0;
      state_q    <= ST_IDLE;
      col_idx_q  <= '0;
      for (int c = 0; c < COLS; c++) hold_q[c] <= '0;
    end else begin
      fill_cnt_q <= fill_cnt_d;
      state_q    <= state_d;
      col_idx_q  <= col_idx_d;
      for (int c = 0; c < COLS; c++) hold_q[c] <= hold_d[c];
    end
  end

  assign ROW_READY   = !full;
  assign WRITE_EN    = accept;
  assign COL_VALID   = (state_q == ST_DRAIN);
  assign COL_OUT     = hold_q[col_idx_q];
  assign COL_IDX     = col_idx_q;
  assign COL_LAST    = COL_VALID && (col_idx_q == IDX_W'(COLS - 1));
  assign FILL_CNT    = fill_cnt_q;
  assign DRAIN_STATE = state_q;

endmodule

// File: tb/tb_transposed_buffer_reader.sv
// Bench for transposed_buffer_reader: a behavioural transposed buffer feeds
// it, and a queue-based block model predicts every output each cycle.
module tb_transposed_buffer_reader;
  import transposed_buffer_reader_pkg::*;

  logic                        CLK = 1'b0;
  logic                        RST_ASYNC_N = 1'b0;
  logic                        ROW_VALID = 1'b0;
  logic                        ROW_READY;
  logic                        WRITE_EN;
  logic signed [COL_W-1:0]     buf_col [COLS];
  logic signed [COL_W-1:0]     COL_OUT;
  logic [IDX_W-1:0]            COL_IDX;
  logic                        COL_VALID;
  logic                        COL_READY = 1'b1;
  logic                        COL_LAST;
  logic [FILL_W-1:0]           FILL_CNT;
  drain_state_e                DRAIN_STATE;
  logic [3:0][SAMPLE_W-1:0]    row_in = '0;

  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  transposed_buffer_reader dut (
    .CLK(CLK), .RST_ASYNC_N(RST_ASYNC_N), .ROW_VALID(ROW_VALID), .ROW_READY(ROW_READY),
    .WRITE_EN(WRITE_EN), .COL_IN_0(buf_col[0]), .COL_IN_1(buf_col[1]), .COL_IN_2(buf_col[2]),
    .COL_IN_3(buf_col[3]), .COL_OUT(COL_OUT), .COL_IDX(COL_IDX), .COL_VALID(COL_VALID),
    .COL_READY(COL_READY), .COL_LAST(COL_LAST), .FILL_CNT(FILL_CNT), .DRAIN_STATE(DRAIN_STATE)
  );

  // Behavioural transposed buffer: newest sample enters at the top bits.
  initial for (int c = 0; c < COLS; c++) buf_col[c] = '0;
  always @(posedge CLK)
    if (WRITE_EN)
      for (int c = 0; c < COLS; c++) buf_col[c] <= {row_in[c], buf_col[c][COL_W-1:SAMPLE_W]};

  // ---------------- reference model / scoreboard ----------------
  logic [3:0][SAMPLE_W-1:0] pend_q[$];
  logic [COL_W-1:0]         exp_q[$];
  logic [COL_W-1:0]         m_col;
  bit                       m_ready, m_valid, m_fire, m_cap;
  int                       rows_acc = 0;
  int                       cols_popped = 0;

  always @(negedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      pend_q.delete();
      exp_q.delete();
    end else begin
      m_ready = pend_q.size() < ROWS;
      m_valid = exp_q.size() != 0;
      checks += 5;
      if (ROW_READY !== m_ready) begin
        errors++; $display("FAIL mon_row_ready: got %b want %b", ROW_READY, m_ready);
      end
      if (WRITE_EN !== (ROW_VALID && m_ready)) begin
        errors++; $display("FAIL mon_write_en: got %b want %b", WRITE_EN, ROW_VALID && m_ready);
      end
      if (FILL_CNT !== FILL_W'(pend_q.size())) begin
        errors++; $display("FAIL mon_fill_cnt: got %0d want %0d", FILL_CNT, pend_q.size());
      end
      if (COL_VALID !== m_valid) begin
        errors++; $display("FAIL mon_col_valid: got %b want %b", COL_VALID, m_valid);
      end
      if (COL_LAST !== (m_valid && exp_q.size() == 1)) begin
        errors++; $display("FAIL mon_col_last: got %b want %b", COL_LAST, m_valid && exp_q.size() == 1);
      end
      if (m_valid) begin
        checks += 2;
        if (COL_IDX !== IDX_W'(COLS - exp_q.size())) begin
          errors++; $display("FAIL mon_col_idx: got %0d want %0d", COL_IDX, COLS - exp_q.size());
        end
        if (COL_OUT !== exp_q[0]) begin
          errors++; $display("FAIL mon_col_out: got %h want %h", COL_OUT, exp_q[0]);
        end
      end else begin
        checks++;
        if (COL_IDX !== '0) begin
          errors++; $display("FAIL mon_idle_idx: got %0d want 0", COL_IDX);
        end
      end
      // advance the model to the state after the coming rising edge
      m_fire = m_valid && COL_READY;
      m_cap  = (pend_q.size() == ROWS) && (!m_valid || (m_fire && exp_q.size() == 1));
      if (m_fire) begin
        void'(exp_q.pop_front());
        cols_popped++;
      end
      if (m_cap) begin
        for (int c = 0; c < COLS; c++) begin
          m_col = '0;
          for (int r = 0; r < ROWS; r++) m_col[r*SAMPLE_W +: SAMPLE_W] = pend_q[r][c];
          exp_q.push_back(m_col);
        end
        pend_q.delete();
      end
      if (ROW_VALID && m_ready) begin
        pend_q.push_back(row_in);
        rows_acc++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_row(input logic [3:0][SAMPLE_W-1:0] r);
    ROW_VALID = 1'b1;
    row_in    = r;
    @(posedge CLK); #1;
    ROW_VALID = 1'b0;
  endtask

  task automatic wait_drained(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || pend_q.size() != 0) && n < 2000) begin
      @(posedge CLK); #1; n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++; $display("FAIL %s_timeout: got %0d pending cols want 0", name, exp_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RST_ASYNC_N = 1'b0; ROW_VALID = 1'b0; COL_READY = 1'b1;
    #1;
    checks += 6;
    if (ROW_READY !== 1'b1) begin errors++; $display("FAIL rst_row_ready: got %b want 1", ROW_READY); end
    if (WRITE_EN  !== 1'b0) begin errors++; $display("FAIL rst_write_en: got %b want 0", WRITE_EN); end
    if (COL_VALID !== 1'b0) begin errors++; $display("FAIL rst_col_valid: got %b want 0", COL_VALID); end
    if (COL_LAST  !== 1'b0) begin errors++; $display("FAIL rst_col_last: got %b want 0", COL_LAST); end
    if (COL_OUT   !== '0)   begin errors++; $display("FAIL rst_col_out: got %h want 0", COL_OUT); end
    if (FILL_CNT  !== '0)   begin errors++; $display("FAIL rst_fill_cnt: got %0d want 0", FILL_CNT); end
    repeat (3) @(posedge CLK);
    #1 RST_ASYNC_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checks++;
      if (ROW_READY !== 1'b1 || COL_VALID !== 1'b0 || FILL_CNT !== '0 || COL_OUT !== '0) begin
        errors++;
        $display("FAIL idle_outputs: got rdy=%b vld=%b fill=%0d out=%h want 1 0 0 0",
                 ROW_READY, COL_VALID, FILL_CNT, COL_OUT);
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_ramp();
    logic [COL_W-1:0] want;
    COL_READY = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      ROW_VALID = 1'b1;
      for (int c = 0; c < COLS; c++) row_in[c] = SAMPLE_W'(16 * r + c);
      @(negedge CLK);
      checks++;
      if (WRITE_EN !== 1'b1) begin errors++; $display("FAIL ramp_write_en row%0d: got %b want 1", r, WRITE_EN); end
      @(posedge CLK); #1;
    end
    ROW_VALID = 1'b0;
    @(negedge CLK);
    checks += 2;
    if (FILL_CNT !== 4'd9) begin errors++; $display("FAIL ramp_full: got %0d want 9", FILL_CNT); end
    if (COL_VALID !== 1'b0) begin errors++; $display("FAIL ramp_early_valid: got %b want 0", COL_VALID); end
    @(posedge CLK); #1;
    for (int k = 0; k < COLS; k++) begin
      want = '0;
      for (int r = 0; r < ROWS; r++) want[r*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(16 * r + k);
      @(negedge CLK);
      checks += 4;
      if (COL_VALID !== 1'b1) begin errors++; $display("FAIL ramp_valid k%0d: got %b want 1", k, COL_VALID); end
      if (COL_IDX !== IDX_W'(k)) begin errors++; $display("FAIL ramp_idx: got %0d want %0d", COL_IDX, k); end
      if (COL_LAST !== (k == 3)) begin errors++; $display("FAIL ramp_last k%0d: got %b want %b", k, COL_LAST, k == 3); end
      if (COL_OUT !== want) begin errors++; $display("FAIL ramp_col k%0d: got %h want %h", k, COL_OUT, want); end
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    checks++;
    if (COL_VALID !== 1'b0) begin errors++; $display("FAIL ramp_after: got %b want 0", COL_VALID); end
    @(posedge CLK); #1;
  endtask

  task automatic test_signed();
    logic [COL_W-1:0] want;
    int n = 0;
    want = '0;
    for (int r = 0; r < ROWS; r++) begin
      want[r*SAMPLE_W +: SAMPLE_W] = (r % 2 == 0) ? 11'h400 : 11'h3ff;
      drive_row((r % 2 == 0) ? {4{11'h400}} : {4{11'h3ff}});
    end
    while (COL_VALID !== 1'b1 && n < 10) begin @(posedge CLK); #1; n++; end
    checks += 3;
    if (COL_OUT !== want) begin errors++; $display("FAIL signed_col: got %h want %h", COL_OUT, want); end
    if ($signed(COL_OUT[SAMPLE_W-1:0]) !== -11'sd1024) begin
      errors++; $display("FAIL signed_lsb: got %0d want -1024", $signed(COL_OUT[SAMPLE_W-1:0]));
    end
    if ($signed(COL_OUT[2*SAMPLE_W-1:SAMPLE_W]) !== 11'sd1023) begin
      errors++; $display("FAIL signed_row1: got %0d want 1023", $signed(COL_OUT[2*SAMPLE_W-1:SAMPLE_W]));
    end
    wait_drained("signed");
  endtask

  task automatic test_stall();
    logic [3:0][SAMPLE_W-1:0] blk_a [ROWS];
    logic [3:0][SAMPLE_W-1:0] blk_b [ROWS];
    logic [COL_W-1:0] col0_a, col0_b;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        blk_a[r][c] = SAMPLE_W'($urandom);
        blk_b[r][c] = SAMPLE_W'($urandom);
      end
      col0_a[r*SAMPLE_W +: SAMPLE_W] = blk_a[r][0];
      col0_b[r*SAMPLE_W +: SAMPLE_W] = blk_b[r][0];
    end
    COL_READY = 1'b1;
    for (int r = 0; r < ROWS; r++) drive_row(blk_a[r]);
    COL_READY = 1'b0;
    @(posedge CLK); #1;
    for (int i = 0; i < 20; i++) begin
      if (i < ROWS) begin ROW_VALID = 1'b1; row_in = blk_b[i]; end
      else ROW_VALID = 1'b0;
      @(negedge CLK);
      checks++;
      if (COL_VALID !== 1'b1 || COL_IDX !== '0 || COL_OUT !== col0_a) begin
        errors++;
        $display("FAIL stall_hold c%0d: got vld=%b idx=%0d out=%h want 1 0 %h", i, COL_VALID, COL_IDX, COL_OUT, col0_a);
      end
      @(posedge CLK); #1;
    end
    ROW_VALID = 1'b0;
    checks += 2;
    if (FILL_CNT !== 4'd9) begin errors++; $display("FAIL stall_fill: got %0d want 9", FILL_CNT); end
    if (ROW_READY !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b want 0", ROW_READY); end
    COL_READY = 1'b1;
    for (int k = 0; k < COLS; k++) begin
      @(negedge CLK);
      checks++;
      if (COL_IDX !== IDX_W'(k) || COL_LAST !== (k == 3)) begin
        errors++; $display("FAIL stall_drain k%0d: got idx=%0d last=%b", k, COL_IDX, COL_LAST);
      end
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    checks++;
    if (COL_VALID !== 1'b1 || COL_IDX !== '0 || COL_OUT !== col0_b || FILL_CNT !== '0) begin
      errors++;
      $display("FAIL no_bubble: got vld=%b idx=%0d fill=%0d out=%h want 1 0 0 %h",
               COL_VALID, COL_IDX, FILL_CNT, COL_OUT, col0_b);
    end
    @(posedge CLK); #1;
    wait_drained("stall");
  endtask

  task automatic test_random();
    int target = rows_acc + 50 * ROWS;
    int pop0   = cols_popped;
    int n      = 0;
    while (rows_acc < target && n < 20000) begin
      ROW_VALID = ($urandom_range(0, 3) != 0) && (rows_acc + 1 < target || !ROW_VALID || 1'b1);
      COL_READY = ($urandom_range(0, 2) != 0);
      for (int c = 0; c < COLS; c++) row_in[c] = SAMPLE_W'($urandom);
      @(negedge CLK);
      if (ROW_VALID && ROW_READY && rows_acc + 1 > target) ROW_VALID = 1'b0;
      @(posedge CLK); #1;
      n++;
    end
    ROW_VALID = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || pend_q.size() != 0) && n < 2000) begin
      COL_READY = ($urandom_range(0, 1) != 0);
      @(posedge CLK); #1; n++;
    end
    COL_READY = 1'b1;
    checks += 2;
    if (rows_acc !== target) begin errors++; $display("FAIL random_rows: got %0d want %0d", rows_acc, target); end
    if (cols_popped - pop0 !== 50 * COLS) begin
      errors++; $display("FAIL random_cols: got %0d want %0d", cols_popped - pop0, 50 * COLS);
    end
  endtask

  task automatic test_reset_mid();
    COL_READY = 1'b1;
    for (int r = 0; r < ROWS; r++) drive_row({4{SAMPLE_W'($urandom)}});
    COL_READY = 1'b0;
    @(posedge CLK); #1;
    for (int r = 0; r < 5; r++) begin
      COL_READY = (r >= 3);
      drive_row({4{SAMPLE_W'($urandom)}});
    end
    COL_READY = 1'b0;
    @(negedge CLK);
    checks++;
    if (FILL_CNT !== 4'd5 || COL_IDX !== 2'd2 || COL_VALID !== 1'b1) begin
      errors++; $display("FAIL mid_setup: got fill=%0d idx=%0d vld=%b want 5 2 1", FILL_CNT, COL_IDX, COL_VALID);
    end
    #2 RST_ASYNC_N = 1'b0;
    #1;
    checks++;
    if (ROW_READY !== 1'b1 || WRITE_EN !== 1'b0 || COL_VALID !== 1'b0 || COL_LAST !== 1'b0 ||
        COL_IDX !== '0 || COL_OUT !== '0 || FILL_CNT !== '0) begin
      errors++;
      $display("FAIL mid_reset: got rdy=%b we=%b vld=%b last=%b idx=%0d fill=%0d out=%h",
               ROW_READY, WRITE_EN, COL_VALID, COL_LAST, COL_IDX, FILL_CNT, COL_OUT);
    end
    @(posedge CLK); #1;
    RST_ASYNC_N = 1'b1;
    COL_READY = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    drive_row({4{SAMPLE_W'($urandom)}});
    @(negedge CLK);
    checks++;
    if (FILL_CNT !== 4'd1) begin errors++; $display("FAIL mid_restart: got %0d want 1", FILL_CNT); end
    @(posedge CLK); #1;
    for (int r = 1; r < ROWS; r++) drive_row({4{SAMPLE_W'($urandom)}});
    wait_drained("mid");
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_signed();
    test_stall();
    test_random();
    test_reset_mid();
    repeat (3) @(posedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
